// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM control-unit types: condition codes and flag bit positions
package arm_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational condition-field evaluation against the NZCV flags
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex
);

  logic w_n, w_z, w_c, w_v;

  always_comb begin
    w_n = i_flags[FLAG_N];
    w_z = i_flags[FLAG_Z];
    w_c = i_flags[FLAG_C];
    w_v = i_flags[FLAG_V];
  end

  // NV is an unimplemented encoding, so it squashes like a failed condition
  always_comb begin
    o_cond_ex = 1'b0;
    case (cond_e'(i_cond))
      EQ: o_cond_ex = w_z;
      NE: o_cond_ex = ~w_z;
      CS: o_cond_ex = w_c;
      CC: o_cond_ex = ~w_c;
      MI: o_cond_ex = w_n;
      PL: o_cond_ex = ~w_n;
      VS: o_cond_ex = w_v;
      VC: o_cond_ex = ~w_v;
      HI: o_cond_ex = w_c & ~w_z;
      LS: o_cond_ex = ~w_c | w_z;
      GE: o_cond_ex = (w_n == w_v);
      LT: o_cond_ex = (w_n != w_v);
      GT: o_cond_ex = ~w_z & (w_n == w_v);
      LE: o_cond_ex = w_z | (w_n != w_v);
      AL: o_cond_ex = 1'b1;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - NZCV flag state and conditional gating of decoder writes; COND_STATS_EN adds exec/squash counters
module cond_logic
  import arm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SquashCount
`endif
);

  logic [1:0] r_nz;
  logic [1:0] r_cv;
  logic       w_cond_ex;
  logic       w_nz_we;
  logic       w_cv_we;

  assign Flags = {r_nz, r_cv};

  cond_check u_cond_check (
    .i_cond    (Cond),
    .i_flags   (Flags),
    .o_cond_ex (w_cond_ex)
  );

  assign CondEx   = w_cond_ex;
  assign PCSrc    = PCS & w_cond_ex;
  assign RegWrite = RegW & w_cond_ex & ~NoWrite;
  assign MemWrite = MemW & w_cond_ex;

  assign w_nz_we = FlagW[1] & w_cond_ex;
  assign w_cv_we = FlagW[0] & w_cond_ex;

  // ALUFlags is only sampled under its enable, so unknowns there never reach the flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nz <= 2'b00;
      r_cv <= 2'b00;
    end else begin
      if (w_nz_we) r_nz <= ALUFlags[3:2];
      if (w_cv_we) r_cv <= ALUFlags[1:0];
    end
  end

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] r_exec_cnt;
  logic [CNT_W-1:0] r_squash_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_exec_cnt   <= '0;
      r_squash_cnt <= '0;
    end else if (w_cond_ex) begin
      r_exec_cnt   <= r_exec_cnt + 1'b1;
    end else begin
      r_squash_cnt <= r_squash_cnt + 1'b1;
    end
  end

  assign ExecCount   = r_exec_cnt;
  assign SquashCount = r_squash_cnt;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// tb/tb_cond_logic.sv - randomized self-checking bench for cond_logic against a flag/condition reference model
module tb_cond_logic;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    Cond, ALUFlags;
  logic [1:0]    FlagW;
  logic          PCS, RegW, MemW, NoWrite;
  logic          PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]    Flags;
`ifdef COND_STATS_EN
  logic [CW-1:0] ExecCount, SquashCount;
`endif

  int checks   = 0;
  int failures = 0;

  // reference state
  bit m_n, m_z, m_c, m_v;
  int m_exec, m_squash;

  always #5 clk = ~clk;

  cond_logic #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags)
`ifdef COND_STATS_EN
    , .ExecCount(ExecCount), .SquashCount(SquashCount)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_pass(input logic [3:0] c);
    case (c)
      4'd0:  return m_z;
      4'd1:  return !m_z;
      4'd2:  return m_c;
      4'd3:  return !m_c;
      4'd4:  return m_n;
      4'd5:  return !m_n;
      4'd6:  return m_v;
      4'd7:  return !m_v;
      4'd8:  return m_c && !m_z;
      4'd9:  return !m_c || m_z;
      4'd10: return m_n == m_v;
      4'd11: return m_n != m_v;
      4'd12: return !m_z && (m_n == m_v);
      4'd13: return m_z || (m_n != m_v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_in(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                        input logic pcs, input logic rw, input logic mw, input logic nw);
    Cond = c; ALUFlags = af; FlagW = fw; PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
  endtask

  // check combinational outputs mid-cycle, then advance the model across the edge
  task automatic cycle(input string tag);
    bit ce;
    ce = model_pass(Cond);
    @(negedge clk);
    check({tag, ".flags"}, 32'(Flags), 32'({m_n, m_z, m_c, m_v}));
    check({tag, ".condex"}, 32'(CondEx), 32'(ce));
    check({tag, ".pcsrc"}, 32'(PCSrc), 32'(PCS && ce));
    check({tag, ".regwrite"}, 32'(RegWrite), 32'(RegW && ce && !NoWrite));
    check({tag, ".memwrite"}, 32'(MemWrite), 32'(MemW && ce));
`ifdef COND_STATS_EN
    check({tag, ".exec"}, 32'(ExecCount), 32'(m_exec % (1 << CW)));
    check({tag, ".squash"}, 32'(SquashCount), 32'(m_squash % (1 << CW)));
`endif
    if (reset) begin
      {m_n, m_z, m_c, m_v} = 4'b0000;
      m_exec = 0;
      m_squash = 0;
    end else begin
      if (FlagW[1] && ce) {m_n, m_z} = ALUFlags[3:2];
      if (FlagW[0] && ce) {m_c, m_v} = ALUFlags[1:0];
      if (ce) m_exec++; else m_squash++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_in(4'he, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    {m_n, m_z, m_c, m_v} = 4'b0000; m_exec = 0; m_squash = 0;
    cycle("reset");
    reset = 1'b0;

    set_in(4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0); cycle("eq_after_reset");
    set_in(4'he, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0); cycle("al_regw");

    set_in(4'he, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1); cycle("cmp");
    set_in(4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0); cycle("beq_taken");
    check("beq_taken.direct", 32'(Flags), 32'h4);

    set_in(4'he, 4'hf, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); cycle("set_all");
    set_in(4'he, 4'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0); cycle("partial_nz");
    check("partial_nz.direct", 32'(Flags), 32'h3);

    set_in(4'he, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); cycle("clear_all");
    set_in(4'h0, 4'hf, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0); cycle("failed_blocks");
    check("failed_blocks.direct", 32'(Flags), 32'h0);

    set_in(4'he, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); cycle("set_n");
    for (int c = 0; c < 16; c++) begin
      set_in(4'(c), 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle($sformatf("n_only_cond%0d", c));
    end

`ifdef COND_STATS_EN
    reset = 1'b1; cycle("stats_reset"); reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_in(4'he, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("al_run");
    end
    #1 check("al_run.wrap", 32'(ExecCount), 32'd4);
`endif

    for (int i = 0; i < 400; i++) begin
      set_in(4'($urandom_range(0, 15)), 4'($urandom), 2'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      reset = ($urandom_range(0, 40) == 0);
      cycle("rand");
    end
    reset = 1'b0;
    set_in(4'he, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
